// File: rtl/video_pkg.sv
// video_pkg: shared pixel, FIFO beat and controller state types for the VGA output path
//   rgb444_t : {R,G,B} 4-bit nibbles, R in the top nibble
//   beat_t   : one buffered AXI-Stream beat {tuser, tlast, data}
//   state_e  : SEEK (hunting for a start-of-frame beat) / RUN (streaming pixels)
package video_pkg;
    typedef logic [2:0][3:0] rgb444_t;
    typedef enum logic {SEEK, RUN} state_e;
    typedef struct packed {
        logic    tuser;
        logic    tlast;
        rgb444_t data;
    } beat_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO, head of queue visible on dout while !empty
//   clk, rst  : clock, asynchronous active-high reset (empties the FIFO)
//   push, din : write a word, ignored when full
//   pop, dout : dout is the head; pop advances it, ignored when empty
//   empty     : no words held
//   full      : DEPTH words held
module sync_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        empty   = wr_q == rd_q;
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = wr_q + (AW+1)'(do_push);
        rd_d    = rd_q + (AW+1)'(do_pop);
        dout    = mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/axis_vga_out.sv
// axis_vga_out: AXI-Stream rgb444 pixels to VGA timing with frame alignment and error recovery
//   aclk, areset        : sole clock, asynchronous active-high reset
//   H_RES, V_RES        : active pixels per line / lines per frame, sampled at frame origin
//   enable              : run timing; low holds counters at (0,0) and the FIFO untouched
//   err_clr             : clears underflow and sync_err (a same-cycle set wins)
//   pix_t*              : AXI-Stream pixel input, tuser = start of frame, tlast = end of line
//   sof                 : one-cycle request for the next frame, at h=0, v=V_RES
//   vga_hsync/vga_vsync : active-low syncs, registered
//   vga_rgb             : pixel colour, registered, black outside active video and in SEEK
//   underflow, sync_err : sticky error flags
module axis_vga_out
    import video_pkg::*;
#(
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int FIFO_DEPTH = 16
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic [15:0]     H_RES,
    input  logic [15:0]     V_RES,
    input  logic            enable,
    input  logic            err_clr,
    input  logic            pix_tvalid,
    output logic            pix_tready,
    input  logic [2:0][3:0] pix_tdata,
    input  logic            pix_tlast,
    input  logic            pix_tuser,
    output logic            sof,
    output logic            vga_hsync,
    output logic            vga_vsync,
    output logic [2:0][3:0] vga_rgb,
    output logic            underflow,
    output logic            sync_err
);
    logic [15:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [15:0] h_res_q, h_res_d, v_res_q, v_res_d, h_res, v_res;
    logic [16:0] h_tot, v_tot, h_sync_lo, v_sync_lo;
    state_e      state_q, state_d;
    rgb444_t     rgb_q, rgb_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        underflow_q, underflow_d, sync_err_q, sync_err_d;
    logic        at_origin, h_wrap, v_wrap, active, last_px;
    logic        run_now, pop, bad, uf_set, se_set, empty, full;
    beat_t       in_beat, head;

    assign in_beat = {pix_tuser, pix_tlast, pix_tdata};

    sync_fifo #(
        .WIDTH($bits(beat_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (aclk),
        .rst  (areset),
        .push (pix_tvalid && pix_tready),
        .din  (in_beat),
        .pop  (pop),
        .dout (head),
        .empty(empty),
        .full (full)
    );

    // Resolution is taken straight from the ports at the frame origin (so the first
    // frame after reset already uses them) and held in registers for the rest of it.
    assign at_origin = h_cnt_q == '0 && v_cnt_q == '0;
    assign h_res     = at_origin ? H_RES : h_res_q;
    assign v_res     = at_origin ? V_RES : v_res_q;

    always_comb begin
        h_res_d     = h_res;
        v_res_d     = v_res;
        h_tot       = {1'b0, h_res} + 17'(H_FP + H_SYNC + H_BP);
        v_tot       = {1'b0, v_res} + 17'(V_FP + V_SYNC + V_BP);
        h_sync_lo   = {1'b0, h_res} + 17'(H_FP);
        v_sync_lo   = {1'b0, v_res} + 17'(V_FP);
        h_wrap      = {1'b0, h_cnt_q} == h_tot - 17'd1;
        v_wrap      = {1'b0, v_cnt_q} == v_tot - 17'd1;
        h_cnt_d     = !enable || h_wrap ? '0 : h_cnt_q + 16'd1;
        v_cnt_d     = !enable || (h_wrap && v_wrap) ? '0 : v_cnt_q + 16'(h_wrap);
        active      = h_cnt_q < h_res && v_cnt_q < v_res;
        last_px     = {1'b0, h_cnt_q} == {1'b0, h_res} - 17'd1;
        // A held start-of-frame beat at the origin is displayed in the same cycle
        // SEEK hands over to RUN, so pixel (0,0) is never skipped.
        run_now     = enable && (state_q == RUN || (at_origin && !empty && head.tuser));
        pop         = enable && (run_now ? active && !empty : !empty && !head.tuser);
        bad         = (at_origin ? !head.tuser : head.tuser) || head.tlast != last_px;
        uf_set      = run_now && active && empty;
        se_set      = run_now && active && !empty && bad;
        state_d     = run_now && !uf_set && !se_set ? RUN : SEEK;
        rgb_d       = run_now && active && !empty && !bad ? head.data : '0;
        hsync_d     = !({1'b0, h_cnt_q} >= h_sync_lo && {1'b0, h_cnt_q} < h_sync_lo + 17'(H_SYNC));
        vsync_d     = !({1'b0, v_cnt_q} >= v_sync_lo && {1'b0, v_cnt_q} < v_sync_lo + 17'(V_SYNC));
        underflow_d = uf_set || (underflow_q && !err_clr);
        sync_err_d  = se_set || (sync_err_q && !err_clr);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            h_res_q     <= '0;
            v_res_q     <= '0;
            state_q     <= SEEK;
            rgb_q       <= '0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            underflow_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            h_res_q     <= h_res_d;
            v_res_q     <= v_res_d;
            state_q     <= state_d;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            underflow_q <= underflow_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign pix_tready = !full && !areset;
    assign sof        = !areset && enable && h_cnt_q == '0 && v_cnt_q == v_res;
    assign vga_hsync  = hsync_q;
    assign vga_vsync  = vsync_q;
    assign vga_rgb    = rgb_q;
    assign underflow  = underflow_q;
    assign sync_err   = sync_err_q;
endmodule
